// File: rtl/debounce_pkg.sv
// ============================================================================
// Module      : debounce_pkg
// Description : Shared types, width helper and default counter widths for the
//               multi-channel debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package debounce_pkg;

  // Ceiling log2 with a floor of 1 bit so that degenerate sizes still give a
  // legal vector width.
  function automatic int clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w = w + 1;
      v = v >>> 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  localparam int STABLE_TICKS_DEF = 10;
  localparam int HOLD_TICKS_DEF   = 1000;

  localparam int CNT_W  = clog2(STABLE_TICKS_DEF + 1);
  localparam int HOLD_W = clog2(HOLD_TICKS_DEF + 1);

  typedef struct packed {
    logic result;
    logic rise;
    logic fall;
    logic hold;
  } chan_out_t;

endpackage : debounce_pkg

`default_nettype wire

// File: rtl/debounce_chan.sv
// ============================================================================
// Module      : debounce_chan
// Description : One debounce channel: 2-flop synchroniser, tick-qualified
//               stability counter, edge pulses and long-press detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = 10,
  parameter int HOLD_TICKS   = 1000,
  parameter bit RESET_LEVEL  = 1'b0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_tick,
  input  logic      i_button,
  output chan_out_t o_chan
);

  localparam int c_CNT_W  = clog2(STABLE_TICKS + 1);
  localparam int c_HOLD_W = clog2(HOLD_TICKS + 1);

  localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(STABLE_TICKS - 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = c_HOLD_W'(HOLD_TICKS);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_TICKS - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);

  logic                r_sync1;
  logic                r_sync2;
  logic                r_result;
  logic                r_rise;
  logic                r_fall;
  logic                r_hold;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_HOLD_W-1:0] r_hcnt;

  // Any cycle where the synchronised input agrees with the accepted level
  // restarts qualification, so a glitch between ticks is never accumulated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= RESET_LEVEL;
      r_sync2  <= RESET_LEVEL;
      r_result <= RESET_LEVEL;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      if (r_sync2 == r_result) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (r_cnt == c_CNT_LAST) begin
          r_result <= r_sync2;
          r_cnt    <= '0;
          r_rise   <= r_sync2;
          r_fall   <= ~r_sync2;
        end else begin
          r_cnt <= r_cnt + c_CNT_ONE;
        end
      end
    end
  end

  // Saturating at HOLD_TICKS makes the hold pulse fire once per press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt <= '0;
      r_hold <= 1'b0;
    end else begin
      r_hold <= 1'b0;
      if (!r_result) begin
        r_hcnt <= '0;
      end else if (i_tick && (r_hcnt != c_HOLD_MAX)) begin
        r_hcnt <= r_hcnt + c_HOLD_ONE;
        r_hold <= (r_hcnt == c_HOLD_LAST);
      end
    end
  end

  always_comb begin
    o_chan.result = r_result;
    o_chan.rise   = r_rise;
    o_chan.fall   = r_fall;
    o_chan.hold   = r_hold;
  end

endmodule : debounce_chan

`default_nettype wire

// File: rtl/debounce_multi.sv
// ============================================================================
// Module      : debounce_multi
// Description : NUM_CH-channel button debouncer with a shared sample-tick
//               prescaler and per-channel level, edge and long-press outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_multi
  import debounce_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int TICK_DIV     = 1000,
  parameter int STABLE_TICKS = 10,
  parameter int HOLD_TICKS   = 1000,
  parameter bit RESET_LEVEL  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] button,
  output logic [NUM_CH-1:0] result,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic [NUM_CH-1:0] hold
);

  localparam int c_PCNT_W = clog2(TICK_DIV);

  localparam logic [c_PCNT_W-1:0] c_PCNT_LAST = c_PCNT_W'(TICK_DIV - 1);
  localparam logic [c_PCNT_W-1:0] c_PCNT_ONE  = c_PCNT_W'(1);

  logic [c_PCNT_W-1:0] r_pcnt;
  logic                r_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_pcnt == c_PCNT_LAST);
      if (r_pcnt == c_PCNT_LAST) begin
        r_pcnt <= '0;
      end else begin
        r_pcnt <= r_pcnt + c_PCNT_ONE;
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      chan_out_t w_out;

      debounce_chan #(
        .STABLE_TICKS (STABLE_TICKS),
        .HOLD_TICKS   (HOLD_TICKS),
        .RESET_LEVEL  (RESET_LEVEL)
      ) u_chan (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_tick   (r_tick),
        .i_button (button[g]),
        .o_chan   (w_out)
      );

      assign result[g] = w_out.result;
      assign rise[g]   = w_out.rise;
      assign fall[g]   = w_out.fall;
      assign hold[g]   = w_out.hold;
    end
  endgenerate

endmodule : debounce_multi

`default_nettype wire

// File: tb/tb_debounce_multi.sv
// ============================================================================
// Module      : tb_debounce_multi
// Description : Directed scoreboard bench for debounce_multi (2 channels,
//               TICK_DIV=4, STABLE_TICKS=3, HOLD_TICKS=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_multi;

  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_HOLD = 2;

  typedef struct {
    int kind;
    int ch;
    int lo;
    int hi;
    bit rel;
  } exp_t;

  typedef struct {
    int kind;
    int ch;
    int cyc;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] button;
  logic [1:0] result;
  logic [1:0] rise;
  logic [1:0] fall;
  logic [1:0] hold;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   k;
  exp_t exp_q[$];
  obs_t obs_q[$];

  debounce_multi #(
    .NUM_CH       (2),
    .TICK_DIV     (4),
    .STABLE_TICKS (3),
    .HOLD_TICKS   (8),
    .RESET_LEVEL  (1'b0)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .button (button),
    .result (result),
    .rise   (rise),
    .fall   (fall),
    .hold   (hold)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse-cycle becomes one observed event; a stretched pulse therefore
  // shows up as an extra event.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) if (rise[c] === 1'b1) obs_q.push_back('{K_RISE, c, cyc});
    for (int c = 0; c < 2; c++) if (fall[c] === 1'b1) obs_q.push_back('{K_FALL, c, cyc});
    for (int c = 0; c < 2; c++) if (hold[c] === 1'b1) obs_q.push_back('{K_HOLD, c, cyc});
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int kind, input int ch, input int lo, input int hi, input bit rel);
    exp_t e;
    e.kind = kind;
    e.ch   = ch;
    e.lo   = lo;
    e.hi   = hi;
    e.rel  = rel;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] want);
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  // Relative windows are measured from the previously matched event's cycle.
  task automatic drain(input string tag);
    exp_t e;
    obs_t o;
    int   prev;
    int   base;
    prev = 0;
    checks++;
    assert (obs_q.size() === exp_q.size())
    else begin
      errors++;
      $error("FAIL %s_count observed=%0d expected=%0d", tag, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e    = exp_q.pop_front();
      o    = obs_q.pop_front();
      base = e.rel ? prev : 0;
      checks++;
      assert (o.kind === e.kind && o.ch === e.ch && o.cyc >= base + e.lo && o.cyc <= base + e.hi)
      else begin
        errors++;
        $error("FAIL %s_event observed=kind%0d/ch%0d@%0d expected=kind%0d/ch%0d@[%0d..%0d]",
               tag, o.kind, o.ch, o.cyc, e.kind, e.ch, base + e.lo, base + e.hi);
      end
      prev = o.cyc;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    // Reset with both inputs high
    rst_n  = 1'b0;
    button = 2'b11;
    cycles(3);
    chk("rst_result", result, 2'b00);
    chk("rst_rise", rise, 2'b00);
    chk("rst_fall", fall, 2'b00);
    chk("rst_hold", hold, 2'b00);
    button = 2'b00;
    cycles(2);
    rst_n = 1'b1;
    cycles(3);
    drain("rst");

    // Clean press and release on ch0
    button[0] = 1'b1;
    k = cyc;
    push_exp(K_RISE, 0, k + 11, k + 15, 1'b0);
    cycles(20);
    chk("s2_press_result", result, 2'b01);
    button[0] = 1'b0;
    k = cyc;
    push_exp(K_FALL, 0, k + 11, k + 15, 1'b0);
    cycles(20);
    chk("s2_release_result", result, 2'b00);
    drain("s2");

    // Bounce on ch0, then settle high
    for (int i = 0; i < 10; i++) begin
      button[0] = (i % 2 == 0);
      cycles(3);
    end
    chk("s3_bounce_result", result, 2'b00);
    button[0] = 1'b1;
    k = cyc;
    push_exp(K_RISE, 0, k + 11, k + 15, 1'b0);
    cycles(20);
    chk("s3_settle_result", result, 2'b01);
    button[0] = 1'b0;
    k = cyc;
    push_exp(K_FALL, 0, k + 11, k + 15, 1'b0);
    cycles(20);
    drain("s3");

    // Long presses on ch1
    for (int p = 0; p < 2; p++) begin
      button[1] = 1'b1;
      k = cyc;
      push_exp(K_RISE, 1, k + 11, k + 15, 1'b0);
      push_exp(K_HOLD, 1, 28, 36, 1'b1);
      cycles(60);
      chk("s4_hold_result", result, 2'b10);
      button[1] = 1'b0;
      k = cyc;
      push_exp(K_FALL, 1, k + 11, k + 15, 1'b0);
      cycles(20);
    end
    drain("s4");

    // Simultaneous press, glitch on ch1, simultaneous release
    button = 2'b11;
    k = cyc;
    push_exp(K_RISE, 0, k + 11, k + 15, 1'b0);
    push_exp(K_RISE, 1, 0, 0, 1'b1);
    push_exp(K_HOLD, 0, 28, 36, 1'b1);
    push_exp(K_HOLD, 1, 0, 0, 1'b1);
    cycles(20);
    chk("s5_both_result", result, 2'b11);
    button[1] = 1'b0;
    cycles(1);
    button[1] = 1'b1;
    cycles(40);
    chk("s5_glitch_result", result, 2'b11);
    button = 2'b00;
    k = cyc;
    push_exp(K_FALL, 0, k + 11, k + 15, 1'b0);
    push_exp(K_FALL, 1, 0, 0, 1'b1);
    cycles(20);
    drain("s5");

    // Reset in the middle of qualification
    button[0] = 1'b1;
    cycles(8);
    rst_n = 1'b0;
    cycles(2);
    chk("s6_in_reset_result", result, 2'b00);
    rst_n = 1'b1;
    k = cyc;
    push_exp(K_RISE, 0, k + 11, k + 15, 1'b0);
    cycles(20);
    chk("s6_result", result, 2'b01);
    drain("s6");

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_result", result, 2'b00);
    chk("async_rise", rise, 2'b00);
    chk("async_fall", fall, 2'b00);
    chk("async_hold", hold, 2'b00);
    cycles(2);
    drain("async");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_debounce_multi

`default_nettype wire
